// File: rtl/pcs_10g_tx_sched.sv
// 10G PCS transmit scheduler: turns MAC beats into registered encoder control blocks
// (start/data/terminate/idle/error) and enforces the inter-packet gap.
// Optional per-frame/abort counters are enabled with `define PCS_TX_SCHED_CNT_EN.
module pcs_10g_tx_sched #(
  parameter int XGMII_DATA_W = 64,
  parameter int XGMII_KEEP_W = 8,
  parameter int IPG_BLOCKS   = 1
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic [XGMII_DATA_W-1:0] s_data_i,
  input  logic [XGMII_KEEP_W-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    gb_pause_i,
  output logic                    out_v_o,
  output logic                    ctrl_v_o,
  output logic                    idle_v_o,
  output logic                    start_o,
  output logic                    term_o,
  output logic                    err_o,
  output logic [XGMII_DATA_W-1:0] data_o,
  output logic [XGMII_KEEP_W-1:0] keep_o
`ifdef PCS_TX_SCHED_CNT_EN
  ,
  output logic [31:0]             tx_frame_cnt_o,
  output logic [15:0]             tx_abort_cnt_o
`endif
);

  typedef enum logic [4:0] {
    IDLE     = 5'b00001,
    DATA     = 5'b00010,
    TERM_DLY = 5'b00100,
    IPG      = 5'b01000,
    DROP     = 5'b10000
  } state_t;

  localparam logic [3:0] IPG_LOAD = 4'(IPG_BLOCKS - 1);

  state_t                  state, state_nxt;
  logic [3:0]              ipg_cnt, ipg_cnt_nxt;
  logic                    term_pend, term_pend_nxt;
  logic                    ctrl_v_n, idle_v_n, start_n, term_n, err_n;
  logic [XGMII_DATA_W-1:0] data_n;
  logic [XGMII_KEEP_W-1:0] keep_n;
  logic                    underrun;
  logic                    accept;

  assign s_ready_o = ~gb_pause_i & (((state == IDLE) & (ipg_cnt == 4'd0)) |
                                    (state == DATA) | (state == DROP));
  assign accept    = s_valid_i & s_ready_o;

  // During a slip the held block is re-presented on the next cycle, so only the valid drops.
  assign out_v_o   = ~gb_pause_i;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a latch behind.
    state_nxt     = state;
    ipg_cnt_nxt   = ipg_cnt;
    term_pend_nxt = term_pend;
    ctrl_v_n      = 1'b1;
    idle_v_n      = 1'b1;
    start_n       = 1'b0;
    term_n        = 1'b0;
    err_n         = 1'b0;
    data_n        = '0;
    keep_n        = '0;
    underrun      = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          idle_v_n = 1'b0;
          start_n  = 1'b1;
          data_n   = s_data_i;
          keep_n   = '1;
          if (s_last_i) begin
            // Single-beat frame: terminate goes out as its own block from TERM_DLY.
            state_nxt     = TERM_DLY;
            term_pend_nxt = 1'b1;
            ipg_cnt_nxt   = IPG_LOAD;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          idle_v_n = 1'b0;
          data_n   = s_data_i;
          keep_n   = s_keep_i;
          if (s_last_i) begin
            term_n      = 1'b1;
            ipg_cnt_nxt = IPG_LOAD;
            state_nxt   = (&s_keep_i) ? TERM_DLY : IPG;
          end else begin
            ctrl_v_n = 1'b0;
          end
        end else begin
          err_n     = 1'b1;
          underrun  = 1'b1;
          state_nxt = DROP;
        end
      end
      TERM_DLY: begin
        if (term_pend) begin
          idle_v_n      = 1'b0;
          term_n        = 1'b1;
          term_pend_nxt = 1'b0;
        end
        // This block already counts toward the gap.
        if (ipg_cnt != 4'd0) begin
          state_nxt   = IPG;
          ipg_cnt_nxt = ipg_cnt - 4'd1;
        end else begin
          state_nxt = IDLE;
        end
      end
      IPG: begin
        if (ipg_cnt == 4'd0) state_nxt = IDLE;
        else                 ipg_cnt_nxt = ipg_cnt - 4'd1;
      end
      DROP: begin
        if (accept && s_last_i) begin
          state_nxt   = IPG;
          ipg_cnt_nxt = IPG_LOAD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      ipg_cnt   <= 4'd0;
      term_pend <= 1'b0;
      ctrl_v_o  <= 1'b1;
      idle_v_o  <= 1'b1;
      start_o   <= 1'b0;
      term_o    <= 1'b0;
      err_o     <= 1'b0;
      data_o    <= '0;
      keep_o    <= '0;
    end else if (!gb_pause_i) begin
      state     <= state_nxt;
      ipg_cnt   <= ipg_cnt_nxt;
      term_pend <= term_pend_nxt;
      ctrl_v_o  <= ctrl_v_n;
      idle_v_o  <= idle_v_n;
      start_o   <= start_n;
      term_o    <= term_n;
      err_o     <= err_n;
      data_o    <= data_n;
      keep_o    <= keep_n;
    end
  end

`ifdef PCS_TX_SCHED_CNT_EN
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tx_frame_cnt_o <= 32'd0;
      tx_abort_cnt_o <= 16'd0;
    end else if (!gb_pause_i) begin
      if (term_n)   tx_frame_cnt_o <= tx_frame_cnt_o + 32'd1;
      if (underrun) tx_abort_cnt_o <= tx_abort_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pcs_10g_tx_sched.sv
// Scoreboard bench for pcs_10g_tx_sched: dut_a uses IPG_BLOCKS=1, dut_b IPG_BLOCKS=3;
// sel routes stimulus and observation to one of them.
module tb_pcs_10g_tx_sched;

  typedef struct packed {
    logic        ctrl_v;
    logic        idle_v;
    logic        start;
    logic        term;
    logic        err;
    logic [63:0] data;
    logic [7:0]  keep;
  } blk_t;

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        p;
    blk_t        e;
    logic        r;
  } row_t;

  logic        clk = 1'b0;
  logic        nreset, s_valid, s_last, gb_pause, sel;
  logic [63:0] s_data;
  logic [7:0]  s_keep;

  logic        ready_a, out_v_a, ctrl_v_a, idle_v_a, start_a, term_a, err_a;
  logic [63:0] data_a;
  logic [7:0]  keep_a;
  logic        ready_b, out_v_b, ctrl_v_b, idle_v_b, start_b, term_b, err_b;
  logic [63:0] data_b;
  logic [7:0]  keep_b;
`ifdef PCS_TX_SCHED_CNT_EN
  logic [31:0] frame_a, frame_b;
  logic [15:0] abort_a, abort_b;
`endif

  blk_t obs, mon_e;
  logic rdy, ov;
  blk_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pcs_10g_tx_sched #(.IPG_BLOCKS(1)) dut_a (
    .clk(clk), .nreset(nreset), .s_valid_i(s_valid & ~sel), .s_ready_o(ready_a),
    .s_data_i(s_data), .s_keep_i(s_keep), .s_last_i(s_last), .gb_pause_i(gb_pause),
    .out_v_o(out_v_a), .ctrl_v_o(ctrl_v_a), .idle_v_o(idle_v_a), .start_o(start_a),
    .term_o(term_a), .err_o(err_a), .data_o(data_a), .keep_o(keep_a)
`ifdef PCS_TX_SCHED_CNT_EN
    , .tx_frame_cnt_o(frame_a), .tx_abort_cnt_o(abort_a)
`endif
  );

  pcs_10g_tx_sched #(.IPG_BLOCKS(3)) dut_b (
    .clk(clk), .nreset(nreset), .s_valid_i(s_valid & sel), .s_ready_o(ready_b),
    .s_data_i(s_data), .s_keep_i(s_keep), .s_last_i(s_last), .gb_pause_i(gb_pause),
    .out_v_o(out_v_b), .ctrl_v_o(ctrl_v_b), .idle_v_o(idle_v_b), .start_o(start_b),
    .term_o(term_b), .err_o(err_b), .data_o(data_b), .keep_o(keep_b)
`ifdef PCS_TX_SCHED_CNT_EN
    , .tx_frame_cnt_o(frame_b), .tx_abort_cnt_o(abort_b)
`endif
  );

  assign obs = sel ? {ctrl_v_b, idle_v_b, start_b, term_b, err_b, data_b, keep_b}
                   : {ctrl_v_a, idle_v_a, start_a, term_a, err_a, data_a, keep_a};
  assign rdy = sel ? ready_b : ready_a;
  assign ov  = sel ? out_v_b : out_v_a;

  function automatic blk_t mk(logic c, logic i, logic s, logic t, logic e,
                              logic [63:0] d, logic [7:0] k);
    return {c, i, s, t, e, d, k};
  endfunction
  function automatic blk_t idle_blk(logic e);
    return mk(1'b1, 1'b1, 1'b0, 1'b0, e, 64'd0, 8'h00);
  endfunction
  function automatic blk_t start_blk(logic [63:0] d);
    return mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, d, 8'hFF);
  endfunction
  function automatic blk_t data_blk(logic [63:0] d, logic [7:0] k);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, d, k);
  endfunction
  function automatic blk_t term_blk(logic [63:0] d, logic [7:0] k);
    return mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, d, k);
  endfunction
  function automatic row_t rw(logic v, logic [63:0] d, logic [7:0] k, logic l, logic p,
                              blk_t e, logic r);
    row_t x;
    x.v = v; x.d = d; x.k = k; x.l = l; x.p = p; x.e = e; x.r = r;
    return x;
  endfunction

  // Each consumed block (out_v high) is checked against the oldest expectation.
  always @(negedge clk) begin
    if (nreset && ov && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (obs !== mon_e) begin
        errors++;
        $display("FAIL block sel=%0d: got c%b i%b s%b t%b e%b d=%h k=%h, expected c%b i%b s%b t%b e%b d=%h k=%h",
                 sel, obs.ctrl_v, obs.idle_v, obs.start, obs.term, obs.err, obs.data, obs.keep,
                 mon_e.ctrl_v, mon_e.idle_v, mon_e.start, mon_e.term, mon_e.err, mon_e.data, mon_e.keep);
      end
    end
  end

  // One clock of stimulus; the expected block for this cycle's decision is queued after the edge.
  task automatic step(input row_t x, output logic r, output logic o);
    s_valid = x.v; s_data = x.d; s_keep = x.k; s_last = x.l; gb_pause = x.p;
    @(negedge clk);
    r = rdy;
    o = ov;
    @(posedge clk);
    if (!x.p) exp_q.push_back(x.e);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 3;
    if (obs !== idle_blk(1'b0)) begin errors++; $display("FAIL reset_block: got %h expected %h", obs, idle_blk(1'b0)); end
    if (ov !== 1'b1)  begin errors++; $display("FAIL reset_out_v: got %b expected 1", ov); end
    if (rdy !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", rdy); end
`ifdef PCS_TX_SCHED_CNT_EN
    checks++;
    if (frame_a !== 32'd0 || abort_a !== 16'd0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", frame_a, abort_a);
    end
`endif
    @(posedge clk); #1;
    nreset = 1'b1;
  endtask

  task automatic test_partial_term();
    row_t rows[$];
    logic r, o;
    rows.push_back(rw(1, 64'hA0A0_0000_0000_0001, 8'h00, 0, 0, start_blk(64'hA0A0_0000_0000_0001), 1));
    rows.push_back(rw(1, 64'hA1A1_0000_0000_0002, 8'hFF, 0, 0, data_blk(64'hA1A1_0000_0000_0002, 8'hFF), 1));
    rows.push_back(rw(1, 64'h0000_0000_A2A2_A2A2, 8'h0F, 1, 0, term_blk(64'h0000_0000_A2A2_A2A2, 8'h0F), 1));
    rows.push_back(rw(1, 64'hA3A3_0000_0000_0003, 8'hFF, 0, 0, idle_blk(1'b0), 0));
    rows.push_back(rw(1, 64'hA3A3_0000_0000_0003, 8'hFF, 0, 0, start_blk(64'hA3A3_0000_0000_0003), 1));
    rows.push_back(rw(1, 64'h0000_0000_0000_00A4, 8'h01, 1, 0, term_blk(64'h0000_0000_0000_00A4, 8'h01), 1));
    rows.push_back(rw(0, 64'd0, 8'h00, 0, 0, idle_blk(1'b0), 0));
    rows.push_back(rw(0, 64'd0, 8'h00, 0, 0, idle_blk(1'b0), 1));
    foreach (rows[i]) begin
      step(rows[i], r, o);
      checks += 2;
      if (r !== rows[i].r) begin errors++; $display("FAIL partial_term row %0d ready: got %b expected %b", i, r, rows[i].r); end
      if (o !== !rows[i].p) begin errors++; $display("FAIL partial_term row %0d out_v: got %b expected %b", i, o, !rows[i].p); end
    end
  endtask

  task automatic test_full_term_ipg();
    row_t rows[$];
    logic r, o;
`ifdef PCS_TX_SCHED_CNT_EN
    logic [31:0] f0;
    f0 = frame_b;
`endif
    sel = 1'b1;
    rows.push_back(rw(1, 64'hB0B0_0000_0000_0001, 8'hFF, 0, 0, start_blk(64'hB0B0_0000_0000_0001), 1));
    rows.push_back(rw(1, 64'hB1B1_B1B1_B1B1_B1B1, 8'hFF, 1, 0, term_blk(64'hB1B1_B1B1_B1B1_B1B1, 8'hFF), 1));
    for (int n = 0; n < 3; n++)
      rows.push_back(rw(1, 64'hB2B2_0000_0000_0002, 8'hFF, 0, 0, idle_blk(1'b0), 0));
    rows.push_back(rw(1, 64'hB2B2_0000_0000_0002, 8'hFF, 0, 0, start_blk(64'hB2B2_0000_0000_0002), 1));
    rows.push_back(rw(1, 64'h0000_0000_00B3_B3B3, 8'h07, 1, 0, term_blk(64'h0000_0000_00B3_B3B3, 8'h07), 1));
    for (int n = 0; n < 3; n++)
      rows.push_back(rw(0, 64'd0, 8'h00, 0, 0, idle_blk(1'b0), 0));
    rows.push_back(rw(0, 64'd0, 8'h00, 0, 0, idle_blk(1'b0), 1));
    foreach (rows[i]) begin
      step(rows[i], r, o);
      checks += 2;
      if (r !== rows[i].r) begin errors++; $display("FAIL full_term_ipg row %0d ready: got %b expected %b", i, r, rows[i].r); end
      if (o !== !rows[i].p) begin errors++; $display("FAIL full_term_ipg row %0d out_v: got %b expected %b", i, o, !rows[i].p); end
    end
`ifdef PCS_TX_SCHED_CNT_EN
    checks += 2;
    if (frame_b - f0 !== 32'd2) begin errors++; $display("FAIL full_term_frame_cnt: got +%0d expected +2", frame_b - f0); end
    if (abort_b !== 16'd0) begin errors++; $display("FAIL full_term_abort_cnt: got %0d expected 0", abort_b); end
`endif
    sel = 1'b0;
  endtask

  task automatic test_single_beat();
    row_t rows[$];
    logic r, o;
`ifdef PCS_TX_SCHED_CNT_EN
    logic [31:0] f0;
    f0 = frame_a;
`endif
    rows.push_back(rw(1, 64'hC0C0_C0C0_0000_0001, 8'hFF, 1, 0, start_blk(64'hC0C0_C0C0_0000_0001), 1));
    rows.push_back(rw(0, 64'd0, 8'h00, 0, 0, term_blk(64'd0, 8'h00), 0));
    rows.push_back(rw(0, 64'd0, 8'h00, 0, 0, idle_blk(1'b0), 1));
    foreach (rows[i]) begin
      step(rows[i], r, o);
      checks += 2;
      if (r !== rows[i].r) begin errors++; $display("FAIL single_beat row %0d ready: got %b expected %b", i, r, rows[i].r); end
      if (o !== !rows[i].p) begin errors++; $display("FAIL single_beat row %0d out_v: got %b expected %b", i, o, !rows[i].p); end
    end
`ifdef PCS_TX_SCHED_CNT_EN
    checks++;
    if (frame_a - f0 !== 32'd1) begin errors++; $display("FAIL single_beat_frame_cnt: got +%0d expected +1", frame_a - f0); end
`endif
  endtask

  task automatic test_underrun();
    row_t rows[$];
    logic r, o;
`ifdef PCS_TX_SCHED_CNT_EN
    logic [31:0] f0;
    f0 = frame_a;
`endif
    rows.push_back(rw(1, 64'hD0D0_0000_0000_0001, 8'hFF, 0, 0, start_blk(64'hD0D0_0000_0000_0001), 1));
    rows.push_back(rw(0, 64'd0, 8'h00, 0, 0, idle_blk(1'b1), 1));
    rows.push_back(rw(1, 64'hD2D2_0000_0000_0002, 8'hFF, 0, 0, idle_blk(1'b0), 1));
    rows.push_back(rw(1, 64'h0000_0000_D3D3_D3D3, 8'h0F, 1, 0, idle_blk(1'b0), 1));
    rows.push_back(rw(0, 64'd0, 8'h00, 0, 0, idle_blk(1'b0), 0));
    rows.push_back(rw(0, 64'd0, 8'h00, 0, 0, idle_blk(1'b0), 1));
    foreach (rows[i]) begin
      step(rows[i], r, o);
      checks += 2;
      if (r !== rows[i].r) begin errors++; $display("FAIL underrun row %0d ready: got %b expected %b", i, r, rows[i].r); end
      if (o !== !rows[i].p) begin errors++; $display("FAIL underrun row %0d out_v: got %b expected %b", i, o, !rows[i].p); end
    end
`ifdef PCS_TX_SCHED_CNT_EN
    checks += 2;
    if (abort_a !== 16'd1) begin errors++; $display("FAIL underrun_abort_cnt: got %0d expected 1", abort_a); end
    if (frame_a !== f0)    begin errors++; $display("FAIL underrun_frame_cnt: got %0d expected %0d", frame_a, f0); end
`endif
  endtask

  task automatic test_pause();
    row_t rows[$];
    logic r, o;
    rows.push_back(rw(1, 64'hE0E0_0000_0000_0001, 8'hFF, 0, 0, start_blk(64'hE0E0_0000_0000_0001), 1));
    rows.push_back(rw(1, 64'hE1E1_0000_0000_0002, 8'hFF, 0, 1, idle_blk(1'b0), 0));
    rows.push_back(rw(1, 64'hE1E1_0000_0000_0002, 8'hFF, 0, 0, data_blk(64'hE1E1_0000_0000_0002, 8'hFF), 1));
    rows.push_back(rw(1, 64'h0000_E2E2_E2E2_E2E2, 8'h3F, 1, 0, term_blk(64'h0000_E2E2_E2E2_E2E2, 8'h3F), 1));
    rows.push_back(rw(0, 64'd0, 8'h00, 0, 0, idle_blk(1'b0), 0));
    rows.push_back(rw(0, 64'd0, 8'h00, 0, 0, idle_blk(1'b0), 1));
    foreach (rows[i]) begin
      step(rows[i], r, o);
      checks += 2;
      if (r !== rows[i].r) begin errors++; $display("FAIL pause row %0d ready: got %b expected %b", i, r, rows[i].r); end
      if (o !== !rows[i].p) begin errors++; $display("FAIL pause row %0d out_v: got %b expected %b", i, o, !rows[i].p); end
    end
  endtask

  task automatic test_reset_mid_frame();
    row_t pre[$];
    row_t post[$];
    logic r, o;
    pre.push_back(rw(1, 64'hF0F0_0000_0000_0001, 8'hFF, 0, 0, start_blk(64'hF0F0_0000_0000_0001), 1));
    pre.push_back(rw(1, 64'hF1F1_0000_0000_0002, 8'hFF, 0, 0, data_blk(64'hF1F1_0000_0000_0002, 8'hFF), 1));
    foreach (pre[i]) begin
      step(pre[i], r, o);
      checks++;
      if (r !== pre[i].r) begin errors++; $display("FAIL reset_mid pre row %0d ready: got %b expected %b", i, r, pre[i].r); end
    end
    nreset  = 1'b0;
    s_valid = 1'b0;
    #1;
    exp_q.delete();
    checks += 2;
    if (obs !== idle_blk(1'b0)) begin errors++; $display("FAIL reset_mid_block: got %h expected %h", obs, idle_blk(1'b0)); end
    if (ov !== 1'b1) begin errors++; $display("FAIL reset_mid_out_v: got %b expected 1", ov); end
`ifdef PCS_TX_SCHED_CNT_EN
    checks++;
    if (abort_a !== 16'd0) begin errors++; $display("FAIL reset_mid_abort_cnt: got %0d expected 0", abort_a); end
`endif
    @(posedge clk); #1;
    nreset = 1'b1;
    post.push_back(rw(1, 64'h9090_0000_0000_0005, 8'hFF, 0, 0, start_blk(64'h9090_0000_0000_0005), 1));
    post.push_back(rw(1, 64'h0000_0000_0000_0091, 8'h01, 1, 0, term_blk(64'h0000_0000_0000_0091, 8'h01), 1));
    post.push_back(rw(0, 64'd0, 8'h00, 0, 0, idle_blk(1'b0), 0));
    post.push_back(rw(0, 64'd0, 8'h00, 0, 0, idle_blk(1'b0), 1));
    foreach (post[i]) begin
      step(post[i], r, o);
      checks += 2;
      if (r !== post[i].r) begin errors++; $display("FAIL reset_mid post row %0d ready: got %b expected %b", i, r, post[i].r); end
      if (o !== !post[i].p) begin errors++; $display("FAIL reset_mid post row %0d out_v: got %b expected %b", i, o, !post[i].p); end
    end
  endtask

  initial begin
    nreset   = 1'b0;
    sel      = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    s_keep   = '0;
    s_last   = 1'b0;
    gb_pause = 1'b0;

    test_reset();
    test_partial_term();
    test_full_term_ipg();
    test_single_beat();
    test_underrun();
    test_pause();
    test_reset_mid_frame();

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending blocks expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
